// File: rtl/bram_port_arbiter_pkg.sv
// Shared types, constants and the byte-lane merge helper for bram_port_arbiter.
package bram_port_arbiter_pkg;

    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic {
        IDLE,
        RMW_WR
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [ARB_BE_W-1:0] FULL_BE = '1;

    // Lanes with a set enable take the new byte; all others keep the RAM contents.
    function automatic logic [ARB_DATA_W-1:0] byte_merge(
        input logic [ARB_DATA_W-1:0] old_word,
        input logic [ARB_DATA_W-1:0] new_word,
        input logic [ARB_BE_W-1:0]   be
    );
        logic [ARB_DATA_W-1:0] result;
        for (int b = 0; b < ARB_BE_W; b++) begin
            result[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/bram_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port word RAM, with RMW for partial writes.
// Optional round-robin conflict resolution: define BRAM_ARB_ROUND_ROBIN_EN.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = ARB_DATA_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              r_i_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [DATA_W-1:0] r_merged;
    logic [ADDR_W-1:0] r_rmw_addr;

    logic [ADDR_W-1:0] w_i_word;
    logic [ADDR_W-1:0] w_d_word;
    logic              w_d_wins;
    logic              w_grant_d;
    logic              w_i_rd;
    logic              w_d_rd;
    logic              w_unused_addr;

    assign w_i_word      = i_addr[ADDR_W+1:2];
    assign w_d_word      = d_addr[ADDR_W+1:2];
    assign w_unused_addr = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

`ifdef BRAM_ARB_ROUND_ROBIN_EN
    logic r_last;

    // An RMW raises d_ready only in its second cycle, so it records a single D grant.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            r_last <= PORT_I;
        end else if (d_ready) begin
            r_last <= PORT_D;
        end else if (i_ready) begin
            r_last <= PORT_I;
        end
    end

    assign w_d_wins = (r_last == PORT_I);
`else
    assign w_d_wins = 1'b1;
`endif

    assign w_grant_d = d_valid && (!i_valid || w_d_wins);

    // All RAM strobes and readies are gated by reset so an aborted RMW never writes.
    always_comb begin
        w_next    = r_state;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = w_d_word;
        bram_din  = d_wdata;
        w_i_rd    = 1'b0;
        w_d_rd    = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        if (!d_we) begin
                            bram_en = 1'b1;
                            d_ready = 1'b1;
                            w_d_rd  = 1'b1;
                        end else if (d_be == FULL_BE) begin
                            bram_en = 1'b1;
                            bram_we = 1'b1;
                            d_ready = 1'b1;
                        end else if (d_be == '0) begin
                            d_ready = 1'b1;
                        end else begin
                            bram_en = 1'b1;
                            w_next  = RMW_WR;
                        end
                    end else if (i_valid) begin
                        bram_en   = 1'b1;
                        bram_addr = w_i_word;
                        i_ready   = 1'b1;
                        w_i_rd    = 1'b1;
                    end
                end
                RMW_WR: begin
                    bram_en   = 1'b1;
                    bram_we   = 1'b1;
                    bram_addr = r_rmw_addr;
                    bram_din  = r_merged;
                    d_ready   = d_valid;
                    w_next    = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state    <= w_next;
            r_i_rvalid <= w_i_rd;
            r_d_rvalid <= w_d_rd;
            if (w_i_rd) begin
                r_i_rdata <= bram_dout;
            end
            if (w_d_rd) begin
                r_d_rdata <= bram_dout;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (r_state == IDLE && w_next == RMW_WR) begin
            r_merged   <= byte_merge(bram_dout, d_wdata, d_be);
            r_rmw_addr <= w_d_word;
        end
    end

    assign i_rvalid = r_i_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: directed stimulus, queued read expectations, negedge monitor.
module tb_bram_port_arbiter;

    logic        clka;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        bram_en;
    logic        bram_we;
    logic [13:0] bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    logic [31:0] mem [0:16383];

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    bram_port_arbiter dut (
        .clka(clka), .rst_n(rst_n),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    assign bram_dout = mem[bram_addr];

    always @(posedge clka) begin
        cyc <= cyc + 1;
        if (bram_en && bram_we) mem[bram_addr] <= bram_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic expect_rd(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cyc  = cyc + 1;
        q.push_back(e);
    endtask

    task automatic pop_check(input logic port, input logic [31:0] data);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid: port %0d data %h with no pending read", port, data);
        end else begin
            e = q.pop_front();
            chk("rd_port", 32'(port), 32'(e.port));
            chk("rd_data", data, e.data);
            chk("rd_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clka) begin
        if (i_rvalid === 1'b1) pop_check(1'b0, i_rdata);
        if (d_rvalid === 1'b1) pop_check(1'b1, d_rdata);
    end

    task automatic idle_in();
        i_valid = 1'b0;
        d_valid = 1'b0;
        d_we    = 1'b0;
        d_be    = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16384; k++) mem[k] = 32'h0;
        mem[14'h10] = 32'hDEADBEEF;
        mem[14'h30] = 32'h55667788;
        rst_n = 1'b0;
        i_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h0;
        idle_in();
        i_valid = 1'b1;
        d_valid = 1'b1;
        tick();
        tick();
        // reset state, with both requesters asserting valid
        chk("rst_i_ready", 32'(i_ready), 0);
        chk("rst_d_ready", 32'(d_ready), 0);
        chk("rst_bram_en", 32'(bram_en), 0);
        chk("rst_bram_we", 32'(bram_we), 0);
        chk("rst_i_rvalid", 32'(i_rvalid), 0);
        chk("rst_d_rvalid", 32'(d_rvalid), 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        idle_in();
        rst_n = 1'b1;
        tick();

        // I read of word 0x10
        i_valid = 1'b1; i_addr = 32'h40;
        #1;
        chk("iread_ready", 32'(i_ready), 1);
        chk("iread_en", 32'(bram_en), 1);
        chk("iread_addr", 32'(bram_addr), 32'h10);
        expect_rd(1'b0, 32'hDEADBEEF);
        tick();
        idle_in();

        // D full write then D read of same word via aliased address
        d_valid = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h80; d_wdata = 32'h12345678;
        #1;
        chk("dfull_ready", 32'(d_ready), 1);
        chk("dfull_we", 32'(bram_we), 1);
        chk("dfull_din", bram_din, 32'h12345678);
        tick();
        d_we = 1'b0; d_addr = 32'hFFFF_0083;
        #1;
        chk("dread_ready", 32'(d_ready), 1);
        chk("dread_addr", 32'(bram_addr), 32'h20);
        expect_rd(1'b1, 32'h12345678);
        tick();
        idle_in();

        // partial write: RMW over two cycles
        mem[14'h20] = 32'hAABBCCDD;
        d_valid = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h80; d_wdata = 32'h00001122;
        #1;
        chk("rmw1_d_ready", 32'(d_ready), 0);
        chk("rmw1_i_ready", 32'(i_ready), 0);
        chk("rmw1_we", 32'(bram_we), 0);
        chk("rmw1_en", 32'(bram_en), 1);
        tick();
        i_valid = 1'b1; i_addr = 32'h40;
        #1;
        chk("rmw2_d_ready", 32'(d_ready), 1);
        chk("rmw2_i_ready", 32'(i_ready), 0);
        chk("rmw2_we", 32'(bram_we), 1);
        chk("rmw2_addr", 32'(bram_addr), 32'h20);
        chk("rmw2_din", bram_din, 32'hAABB1122);
        tick();
        chk("rmw_mem", mem[14'h20], 32'hAABB1122);
        d_valid = 1'b0;
        #1;
        chk("post_rmw_i_ready", 32'(i_ready), 1);
        expect_rd(1'b0, 32'hDEADBEEF);
        tick();

        // both ports reading for 4 cycles
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'hC0;
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            #1;
            chk("conf_d_ready", 32'(d_ready), 32'(exp_d));
            chk("conf_i_ready", 32'(i_ready), 32'(!exp_d));
            if (exp_d) expect_rd(1'b1, 32'h55667788);
            else       expect_rd(1'b0, 32'hDEADBEEF);
            tick();
        end
        idle_in();

        // reset asserted during RMW_WR of a single-byte write
        d_valid = 1'b1; d_we = 1'b1; d_be = 4'b0001; d_addr = 32'hC0; d_wdata = 32'h000000AA;
        #1;
        chk("rmwrst1_d_ready", 32'(d_ready), 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rmwrst_we", 32'(bram_we), 0);
        chk("rmwrst_d_ready", 32'(d_ready), 0);
        tick();
        rst_n = 1'b1;
        idle_in();
        #1;
        chk("rmwrst_mem", mem[14'h30], 32'h55667788);
        chk("rmwrst_en", 32'(bram_en), 0);
        chk("rmwrst_d_rvalid", 32'(d_rvalid), 0);
        chk("rmwrst_d_rdata", d_rdata, 0);
        chk("rmwrst_i_rdata", i_rdata, 0);
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'hC0;
        #1;
        chk("rmwrst_idle_read", 32'(d_ready), 1);
        expect_rd(1'b1, 32'h55667788);
        tick();
        idle_in();

        // zero byte-enable write
        d_valid = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 32'hC0; d_wdata = 32'hFFFFFFFF;
        #1;
        chk("be0_ready", 32'(d_ready), 1);
        chk("be0_we", 32'(bram_we), 0);
        tick();
        idle_in();
        chk("be0_mem", mem[14'h30], 32'h55667788);

        tick();
        tick();
        tick();
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
